// File: rtl/uart_ctrl_pkg.sv
// Shared UART register map, status bit positions and transmit-scheduler state encoding.
package uart_ctrl_pkg;

    localparam logic [2:0]  UART_TX_ADDR   = 3'd0;
    localparam logic [2:0]  UART_STAT_ADDR = 3'd1;
    localparam int unsigned STAT_BUSY_BIT  = 0;
    localparam int unsigned IDX_W          = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POLL,
        ST_RDWAIT,
        ST_CHECK,
        ST_WRITE,
        ST_SETTLE
    } tx_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr (cyclically) wins.
module rr_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any
);

    localparam int unsigned SUM_W = IDX_W + 1;

    // ptr < N and off < N, so a single conditional subtract is enough for the wrap.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] a,
                                                   input logic [IDX_W-1:0] off);
        logic [SUM_W-1:0] sum;
        sum = {1'b0, a} + {1'b0, off};
        if (sum >= SUM_W'(N)) begin
            sum = sum - SUM_W'(N);
        end
        return sum[IDX_W-1:0];
    endfunction

    logic [IDX_W-1:0] idx;

    // Scan from the farthest offset down so the nearest valid requester is assigned last.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = wrap_add(ptr, IDX_W'(k));
            for (int i = 0; i < N; i++) begin
                if ((IDX_W'(i) == idx) && req[i]) begin
                    gnt     = '0;
                    gnt[i]  = 1'b1;
                    gnt_idx = idx;
                    any     = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin byte scheduler: grants one source, polls UART status until idle,
// then issues a single TX data write. Bus outputs are registered.
module uart_tx_scheduler
    import uart_ctrl_pkg::*;
#(
    parameter int unsigned N_REQ     = 4,
    parameter logic [2:0]  TX_ADDR   = UART_TX_ADDR,
    parameter logic [2:0]  STAT_ADDR = UART_STAT_ADDR,
    parameter int unsigned BUSY_BIT  = STAT_BUSY_BIT,
    parameter int unsigned TO_W      = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   req_ready,
    output logic               uart_cs,
    output logic               uart_nrw,
    output logic [2:0]         uart_add,
    output logic [7:0]         uart_data_in,
    input  logic [7:0]         uart_data_out,
    output logic               busy,
    output logic [2:0]         grant_id,
    output logic               err_timeout
);

    tx_state_e        state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic [N_REQ-1:0] req_ready_q, req_ready_d;
    logic             cs_q, cs_d;
    logic             nrw_q, nrw_d;
    logic [2:0]       add_q, add_d;
    logic [7:0]       data_in_q, data_in_d;
    logic             busy_q, busy_d;
    logic [2:0]       grant_id_q, grant_id_d;
    logic             err_q, err_d;

    logic [N_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_any;
    logic [7:0]       sel_byte;
    logic             stat_busy;
    logic             unused_stat;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .any     (arb_any)
    );

    // Only the busy flag of the status register matters here.
    assign stat_busy   = uart_data_out[BUSY_BIT];
    assign unused_stat = ^uart_data_out;

    always_comb begin
        sel_byte = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_gnt[i]) begin
                sel_byte = req_data[8*i +: 8];
            end
        end
    end

    // Next-state and next-output logic; outputs reflect the state of the previous cycle.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        to_cnt_d    = to_cnt_q;
        tx_byte_d   = tx_byte_q;
        req_ready_d = '0;
        cs_d        = 1'b0;
        nrw_d       = 1'b0;
        add_d       = add_q;
        data_in_d   = data_in_q;
        busy_d      = (state_q != ST_IDLE);
        grant_id_d  = grant_id_q;
        err_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    req_ready_d = arb_gnt;
                    tx_byte_d   = sel_byte;
                    grant_id_d  = arb_idx;
                    rr_ptr_d    = (arb_idx == IDX_W'(N_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
                    to_cnt_d    = '0;
                    state_d     = ST_POLL;
                end
            end
            ST_POLL: begin
                cs_d    = 1'b1;
                nrw_d   = 1'b0;
                add_d   = STAT_ADDR;
                state_d = ST_RDWAIT;
            end
            ST_RDWAIT: begin
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (!stat_busy) begin
                    state_d = ST_WRITE;
                end else if (&to_cnt_q) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                    state_d  = ST_POLL;
                end
            end
            ST_WRITE: begin
                cs_d      = 1'b1;
                nrw_d     = 1'b1;
                add_d     = TX_ADDR;
                data_in_d = tx_byte_q;
                state_d   = ST_SETTLE;
            end
            ST_SETTLE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            to_cnt_q    <= '0;
            tx_byte_q   <= '0;
            req_ready_q <= '0;
            cs_q        <= 1'b0;
            nrw_q       <= 1'b0;
            add_q       <= '0;
            data_in_q   <= '0;
            busy_q      <= 1'b0;
            grant_id_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            to_cnt_q    <= to_cnt_d;
            tx_byte_q   <= tx_byte_d;
            req_ready_q <= req_ready_d;
            cs_q        <= cs_d;
            nrw_q       <= nrw_d;
            add_q       <= add_d;
            data_in_q   <= data_in_d;
            busy_q      <= busy_d;
            grant_id_q  <= grant_id_d;
            err_q       <= err_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign uart_cs      = cs_q;
    assign uart_nrw     = nrw_q;
    assign uart_add     = add_q;
    assign uart_data_in = data_in_q;
    assign busy         = busy_q;
    assign grant_id     = grant_id_q;
    assign err_timeout  = err_q;

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Round-robin transmit scheduler that shares the UART peripheral's register port between `N_REQ` on-FPGA byte sources, such as keyboard scan channels and status reporters. It accepts one byte per grant and polls the UART status register until the transmitter is idle. It then issues a single-cycle write to the TX data register. It sits between the byte sources and the UART core, on the same `clk` domain as the UART core.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (2..8).
- `TX_ADDR`, 3'd0: UART TX data register address.
- `STAT_ADDR`, 3'd1: UART status register address.
- `BUSY_BIT`, 0: status bit that is 1 while the transmitter is busy.
- `TO_W`, 12: width of the poll-timeout counter.

Ports:
- `clk`, in, 1: single clock; all logic is on its rising edge.
- `reset`, in, 1: synchronous reset, active-high.
- `req_valid`, in, N_REQ: requester i has a byte pending.
- `req_data`, in, 8*N_REQ: byte for requester i, at bits [8i+7:8i].
- `req_ready`, out, N_REQ: one-hot, 1-cycle pulse; the byte of requester i is taken this cycle.
- `uart_cs`, out, 1: chip select to the UART core.
- `uart_nrw`, out, 1: 1 means write strobe, 0 means read.
- `uart_add`, out, 3: register address.
- `uart_data_in`, out, 8: write data.
- `uart_data_out`, in, 8: read data, valid 1 cycle after the read is asserted.
- `busy`, out, 1: high in every state except IDLE.
- `grant_id`, out, 3: index of the current or last granted requester.
- `err_timeout`, out, 1: 1-cycle pulse when a byte is dropped after timeout.

## Operation
- FSM states: IDLE, POLL, RDWAIT, CHECK, WRITE, SETTLE.
- IDLE:
  - If any `req_valid` is set, pick the winner round-robin, starting at `rr_ptr`.
  - Pulse `req_ready[win]`, latch `req_data[win]` into `tx_byte`, set `grant_id=win`, set `rr_ptr=(win+1) mod N_REQ`, clear `to_cnt`, go to POLL.
  - If no `req_valid` is set, stay in IDLE; `rr_ptr` is unchanged.
- POLL: drive `uart_cs=1`, `uart_nrw=0`, `uart_add=STAT_ADDR`, then go to RDWAIT.
- RDWAIT: deassert `uart_cs`, then go to CHECK.
- CHECK: sample `uart_data_out[BUSY_BIT]`.
  - If 0, go to WRITE.
  - If 1 and `to_cnt == 2^TO_W-1`: pulse `err_timeout`, discard `tx_byte`, go to IDLE.
  - Otherwise, increment `to_cnt` and go to POLL.
- WRITE: drive `uart_cs=1`, `uart_nrw=1`, `uart_add=TX_ADDR`, `uart_data_in=tx_byte` for exactly 1 cycle, then go to SETTLE.
- SETTLE: 1 idle cycle so the UART busy flag can assert, then go to IDLE.
- Round-robin: the requester just served has the lowest priority on the next arbitration. A requester that drops `req_valid` before its grant loses nothing and is not granted.
- `req_valid` is sampled only in IDLE. Requests raised during a transfer wait; there is no buffering beyond `tx_byte`.
- `uart_cs` and `uart_nrw` are 0 in every state except POLL and WRITE. `uart_add` and `uart_data_in` hold their last values outside those states.

## Timing
- Reset values:
  - `uart_cs`, `uart_nrw`, `busy`, `err_timeout` = 0.
  - `uart_add` = 0, `uart_data_in` = 0, `grant_id` = 0.
  - `req_ready` = 0, `rr_ptr` = 0, `to_cnt` = 0, state = IDLE.
- `reset` asserted mid-transfer:
  - Next state is IDLE; the latched byte is lost.
  - No write strobe is issued in or after the reset cycle.
- Best-case latency, UART idle:
  - Grant at cycle 0, POLL at 1, RDWAIT at 2, CHECK at 3, WRITE at 4, SETTLE at 5.
  - Next grant possible at cycle 6, so minimum spacing is 6 cycles per byte.
- Each busy poll adds 3 cycles (POLL, RDWAIT, CHECK).
- Timeout fires after 2^TO_W busy samples.
- `req_ready` and the write strobe never occur in the same cycle.

## Structure
- Shared package `uart_ctrl_pkg` holds:
  - UART register address constants (TX, STAT).
  - Status bit positions.
  - FSM state encoding.
- Sub-module `rr_arbiter`:
  - Inputs: `req[N]`, `ptr`.
  - Outputs: one-hot `gnt[N]`, `gnt_idx`, `any`.
  - Purely combinational.
  - Instantiated once; the FSM owns `rr_ptr`.

## Test plan
- Single request, UART idle: `req_valid=4'b0010`, byte 8'hA5 → `req_ready[1]` pulses at cycle 0; status read at cycle 1; write of `uart_add=0`, `uart_data_in=8'hA5` at cycle 4; `busy` drops at cycle 6.
- All four requesters valid continuously → grants occur in order 0,1,2,3,0, each 6 cycles apart.
- UART model reports busy for 3 polls → 3 extra POLL/RDWAIT/CHECK loops; write lands at cycle 13; no `err_timeout`.
- UART held busy with `TO_W=2` → 4 busy samples, then `err_timeout` pulses once; no write strobe; next grant is possible.
- `reset` asserted during CHECK → all outputs return to reset values next cycle; no write in the following 10 cycles with `req_valid=0`.
- Requester 2 drops `req_valid` while requester 0 is being served; requester 3 is valid → next grant goes to 3, and requester 2 never sees `req_ready`.
